// File: rtl/output_arbiter.sv
// Output-port stage of a mesh router: round-robin arbitration over five input
// interfaces, a one-entry flit register, and a send/receive link to downstream.
module output_arbiter #(
    parameter int         DATA_WIDTH = 64,
    parameter logic [4:0] PORT_MASK  = 5'b11111
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4:0]              req,
    input  logic [5*DATA_WIDTH-1:0] datai,
    output logic [4:0]              buffer_clear,
    output logic                    so,
    input  logic                    ri,
    output logic [DATA_WIDTH-1:0]   datao,
    output logic [2:0]              grant_id,
    output logic                    state_dbg
);

    // Link handshake: datao/grant_id are valid while so=1 and stay frozen until
    // an edge with so=1 and ri=1 (transfer); a new flit may load on that same edge.
    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [2:0]              ptr_q, ptr_d;
    logic [2:0]              gid_q, gid_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;

    logic [4:0]              eff;
    logic [2:0]              win;
    logic                    found;
    logic [3:0]              scan;
    logic                    load;
    logic [DATA_WIDTH-1:0]   win_data;

    assign eff = req & PORT_MASK;

    // Search starts at ptr and wraps modulo 5; the first requester wins.
    always_comb begin
        win   = 3'd0;
        found = 1'b0;
        scan  = 4'd0;
        for (int k = 0; k < 5; k++) begin
            scan = {1'b0, ptr_q} + 4'(k);
            if (scan >= 4'd5) begin
                scan = scan - 4'd5;
            end
            if (!found && eff[scan[2:0]]) begin
                win   = scan[2:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        win_data = '0;
        for (int i = 0; i < 5; i++) begin
            if (win == 3'(i)) begin
                win_data = datai[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign load = found && ((state_q == IDLE) || ri);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gid_d        = gid_q;
        data_d       = data_q;
        buffer_clear = 5'b00000;
        so           = (state_q == SEND);
        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (ri) begin
                    state_d = load ? SEND : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            buffer_clear = 5'b00001 << win;
            data_d       = win_data;
            gid_d        = win;
            ptr_d        = (win == 3'd4) ? 3'd0 : win + 3'd1;
        end
        // The clear line must stay quiet while reset is held, even with requests pending.
        if (!rst) begin
            buffer_clear = 5'b00000;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            gid_q   <= 3'd0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gid_q   <= gid_d;
            data_q  <= data_d;
        end
    end

    assign datao     = data_q;
    assign grant_id  = gid_q;
    assign state_dbg = state_q;

endmodule
